// File: rtl/mips_mem_pkg.sv
// ----------------------------------------------------------------------------
// mips_mem_pkg : shared constants and state type for the MIPS data-memory slice
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mips_mem_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;
  localparam int          CNT_W    = 16;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_ram_1w2r.sv
// ----------------------------------------------------------------------------
// dmem_ram_1w2r : one sync write port, write-first core read, read-first debug read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_ram_1w2r #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [WORD_W-1:0]     wrData,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [WORD_W-1:0]     rdData,
  input  logic                  dbgEn,
  input  logic [ADDR_WIDTH-1:0] dbgAddr,
  output logic [WORD_W-1:0]     dbgData
);

  logic [WORD_W-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [WORD_W-1:0] r_rdData;
  logic [WORD_W-1:0] r_dbgData;

  always_ff @(posedge clk) begin
    if (wrEn) begin
      r_mem[wrAddr] <= wrData;
    end
  end

  // Core port bypasses the write data on an address match; debug port never does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdData  <= '0;
      r_dbgData <= '0;
    end else begin
      if (rdEn) begin
        r_rdData <= (wrEn && (wrAddr == rdAddr)) ? wrData : r_mem[rdAddr];
      end
      r_dbgData <= dbgEn ? r_mem[dbgAddr] : '0;
    end
  end

  assign rdData  = r_rdData;
  assign dbgData = r_dbgData;

endmodule

`default_nettype wire

// File: rtl/mips_dmem_responder.sv
// ----------------------------------------------------------------------------
// mips_dmem_responder : data-memory responder with post-reset clear, error flag and counters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_dout,
  output logic [31:0]           mem_din,
  output logic                  mem_ready,
  output logic                  mem_err,
  input  logic                  err_clr,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [31:0]           dbg_data,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX    = {ADDR_WIDTH{1'b1}};
  localparam state_t                c_RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [CNT_W-1:0]      c_CNT_MAX     = {CNT_W{1'b1}};

  state_t                  r_state;
  state_t                  w_nextState;
  logic [ADDR_WIDTH-1:0]   r_clrIdx;
  logic                    w_clearing;
  logic                    w_running;

  logic [31:0]             w_offset;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_valid;
  logic                    w_rdOk;
  logic                    w_wrOk;
  logic                    w_badReq;
  logic                    w_badRd;

  logic                    r_badSel;
  logic                    r_err;
  logic [CNT_W-1:0]        r_rdCount;
  logic [CNT_W-1:0]        r_wrCount;
  logic [WORD_W-1:0]       w_ramRdData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_RESET_STATE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_CLEAR: if (r_clrIdx == c_LAST_IDX) w_nextState = ST_RUN;
      ST_RUN:   w_nextState = ST_RUN;
      default:  w_nextState = c_RESET_STATE;
    endcase
  end

  always_comb begin
    w_clearing = (r_state == ST_CLEAR);
    w_running  = (r_state == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clrIdx <= '0;
    end else if (w_clearing) begin
      r_clrIdx <= r_clrIdx + 1'b1;
    end
  end

  // Unsigned subtraction: an address below BASE_ADDR wraps high and fails the range test.
  assign w_offset = mem_addr - BASE_ADDR;
  assign w_idx    = w_offset[ADDR_WIDTH+1:2];
  assign w_valid  = ((mem_addr[1:0] | w_offset[1:0]) == 2'b00) &&
                    (w_offset[31:ADDR_WIDTH+2] == '0);
  assign w_rdOk   = w_running & mem_ren & w_valid;
  assign w_wrOk   = w_running & mem_wen & w_valid;
  assign w_badReq = w_running & (mem_ren | mem_wen) & ~w_valid;
  assign w_badRd  = w_running & mem_ren & ~w_valid;

  dmem_ram_1w2r #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_W     (WORD_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wrEn    (w_clearing | w_wrOk),
    .wrAddr  (w_clearing ? r_clrIdx : w_idx),
    .wrData  (w_clearing ? '0 : mem_dout),
    .rdEn    (w_rdOk),
    .rdAddr  (w_idx),
    .rdData  (w_ramRdData),
    .dbgEn   (w_running),
    .dbgAddr (dbg_addr),
    .dbgData (dbg_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_badSel  <= 1'b0;
      r_err     <= 1'b0;
      r_rdCount <= '0;
      r_wrCount <= '0;
    end else begin
      if (w_rdOk) begin
        r_badSel <= 1'b0;
      end else if (w_badRd) begin
        r_badSel <= 1'b1;
      end
      if (w_badReq) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
      if (w_rdOk && (r_rdCount != c_CNT_MAX)) begin
        r_rdCount <= r_rdCount + 1'b1;
      end
      if (w_wrOk && (r_wrCount != c_CNT_MAX)) begin
        r_wrCount <= r_wrCount + 1'b1;
      end
    end
  end

  assign mem_din   = r_badSel ? BAD_DATA : w_ramRdData;
  assign mem_ready = w_running;
  assign mem_err   = r_err;
  assign rd_count  = r_rdCount;
  assign wr_count  = r_wrCount;

endmodule

`default_nettype wire

// File: tb/tb_mips_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_mips_dmem_responder : directed plus random stimulus against a word-array reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mips_dmem_responder;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_ready;
  logic        mem_err;
  logic        err_clr;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mMem [DEPTH];
  int          mClearLeft;
  logic [31:0] mDin;
  logic [31:0] mDbg;
  logic        mErr;
  logic [15:0] mRd;
  logic [15:0] mWr;

  mips_dmem_responder #(
    .ADDR_WIDTH     (4),
    .BASE_ADDR      (32'h0),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_ready (mem_ready),
    .mem_err   (mem_err),
    .err_clr   (err_clr),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic model_reset();
    mDin = '0; mDbg = '0; mErr = 1'b0; mRd = '0; mWr = '0;
    mClearLeft = DEPTH;
    for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
  endtask

  task automatic model_step();
    logic [31:0] off;
    bit          ok;
    int          w;
    if (!rst) begin
      model_reset();
      return;
    end
    if (mClearLeft > 0) begin
      mClearLeft--;
      mDbg = '0;
      if (err_clr) mErr = 1'b0;
      return;
    end
    off = mem_addr;
    ok  = (mem_addr % 4 == 0) && (off / 4 < DEPTH);
    w   = ok ? int'(off / 4) : 0;
    mDbg = mMem[dbg_addr];
    if ((mem_ren || mem_wen) && !ok) mErr = 1'b1;
    else if (err_clr) mErr = 1'b0;
    if (mem_ren) mDin = ok ? (mem_wen ? mem_dout : mMem[w]) : 32'hDEAD_BEEF;
    if (ok && mem_wen) begin
      mMem[w] = mem_dout;
      if (mWr != 16'hFFFF) mWr++;
    end
    if (ok && mem_ren && mRd != 16'hFFFF) mRd++;
  endtask

  task automatic compare_all();
    chk("mem_din",   mem_din, mDin);
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, (rst && mClearLeft == 0)});
    chk("mem_err",   {31'b0, mem_err}, {31'b0, mErr});
    chk("dbg_data",  dbg_data, mDbg);
    chk("rd_count",  {16'b0, rd_count}, {16'b0, mRd});
    chk("wr_count",  {16'b0, wr_count}, {16'b0, mWr});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] dout, input logic clr, input logic [3:0] dbg);
    mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = dout;
    err_clr = clr; dbg_addr = dbg;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
  endtask

  // Asynchronous reset taken between clock edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    rst = 1'b0;
    idle();
    model_reset();
    #3;
    tick();
    rst = 1'b1;

    // Clear phase lasts DEPTH cycles, then every word reads zero.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 32'h8, 32'hCAFE_0000 + i, 1'b0, 4'h2);
      tick();
    end
    chk("t1_ready", {31'b0, mem_ready}, 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, i * 4, 32'h0, 1'b0, 4'(i));
      tick();
      chk("t1_word", mem_din, 32'h0);
    end

    // Randomized traffic, mostly valid addresses.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = $urandom_range(0, DEPTH - 1) << 2;
      else if (r == 7) a = $urandom_range(0, 127);
      else             a = $urandom;
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, $urandom,
            $urandom_range(0, 5) == 0, 4'($urandom_range(0, DEPTH - 1)));
      tick();
    end

    idle();
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick();

    // Write then read back.
    drive(1'b0, 1'b1, 32'h8, 32'h1234_5678, 1'b0, 4'h0);
    tick();
    drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 4'h0);
    tick();
    idle();
    chk("t2_din", mem_din, 32'h1234_5678);
    chk("t2_wr", {16'b0, wr_count}, 32'd1);
    chk("t2_rd", {16'b0, rd_count}, 32'd1);

    // Simultaneous read+write at one index; debug port shows the old word.
    drive(1'b1, 1'b1, 32'h4, 32'hA5A5_A5A5, 1'b0, 4'h1);
    tick();
    chk("t3_din", mem_din, 32'hA5A5_A5A5);
    chk("t3_dbg_old", dbg_data, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h1);
    tick();
    chk("t3_dbg_new", dbg_data, 32'hA5A5_A5A5);

    // Bad addresses: misaligned and out of range.
    drive(1'b1, 1'b0, 32'h6, 32'h0, 1'b0, 4'h0);
    tick();
    chk("t4_mis_din", mem_din, 32'hDEAD_BEEF);
    chk("t4_mis_err", {31'b0, mem_err}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'h0);
    tick();
    chk("t4_clr", {31'b0, mem_err}, 32'h0);
    drive(1'b1, 1'b1, 32'h40, 32'h5555_AAAA, 1'b0, 4'h0);
    tick();
    chk("t4_oor_din", mem_din, 32'hDEAD_BEEF);
    chk("t4_oor_err", {31'b0, mem_err}, 32'h1);
    chk("t4_rd_same", {16'b0, rd_count}, 32'd2);
    chk("t4_wr_same", {16'b0, wr_count}, 32'd2);
    drive(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 4'h0);
    tick();
    chk("t4_set_wins", {31'b0, mem_err}, 32'h1);
    drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 4'h0);
    tick();
    chk("t4_ram_kept", mem_din, 32'h1234_5678);

    // Read counter saturation.
    idle();
    force dut.r_rdCount = 16'hFFFE;
    #1;
    release dut.r_rdCount;
    mRd = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h4 * i, 32'h0, 1'b0, 4'h0);
      tick();
    end
    chk("t5_sat", {16'b0, rd_count}, 32'h0000_FFFF);

    // Reset mid-RUN, then again mid-CLEAR at index 7; writes during CLEAR are dropped.
    idle();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 32'h8, 32'hFFFF_0000, 1'b0, 4'h2);
      tick();
    end
    do_reset();
    chk("t6_ready_low", {31'b0, mem_ready}, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, (i % DEPTH) * 4, 32'h0BAD_0000 + i, 1'b0, 4'h0);
      tick();
    end
    chk("t6_ready", {31'b0, mem_ready}, 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, i * 4, 32'h0, 1'b0, 4'(i));
      tick();
      chk("t6_word", mem_din, 32'h0);
    end
    chk("t6_wr", {16'b0, wr_count}, 32'd0);

    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
